// File: rtl/sar_logic_if.sv
// Bundles the SAR engine's conversion-control and analog-front-end signals.
// master = controller/front-end side, slave = the sar_logic engine.
interface sar_logic_if #(
    parameter int NUM_BITS = 4
);
    logic                sample_sig;
    logic                cmp_in;
    logic                overrun_clr;
    logic                sample_hold;
    logic [NUM_BITS-1:0] dac_code;
    logic [NUM_BITS-1:0] data_out;
    logic                data_valid;
    logic                busy;
    logic                overrun;

    modport master (
        output sample_sig, cmp_in, overrun_clr,
        input  sample_hold, dac_code, data_out, data_valid, busy, overrun
    );

    modport slave (
        input  sample_sig, cmp_in, overrun_clr,
        output sample_hold, dac_code, data_out, data_valid, busy, overrun
    );
endinterface

// File: rtl/sar_logic.sv
// Successive-approximation engine: track/hold, NUM_BITS-step binary search, result pulse.
// Define SAR_OVERRUN_EN to enable the sticky overrun flag for early sample_sig pulses.
module sar_logic #(
    parameter int NUM_BITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    sar_logic_if.slave  bus
);
    localparam int IW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
    localparam logic [NUM_BITS-1:0] ONE     = NUM_BITS'(1);
    localparam logic [NUM_BITS-1:0] MSB     = ONE << (NUM_BITS - 1);
    localparam logic [IW-1:0]       IDX_TOP = IW'(NUM_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        CONVERT
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [IW-1:0]       idx;
    logic [IW-1:0]       idx_dn;
    logic                last_bit;
    logic [NUM_BITS-1:0] dac_code;
    logic [NUM_BITS-1:0] data_out;
    logic [NUM_BITS-1:0] decided;
    logic [NUM_BITS-1:0] trial_next;
    logic                data_valid;
    logic                busy;
    logic                sample_hold;
    logic                overrun;

    assign last_bit = (idx == '0);
    assign idx_dn   = idx - IW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.sample_sig) next_state = SAMPLE;
            SAMPLE:  next_state = CONVERT;
            CONVERT: if (last_bit) next_state = bus.sample_sig ? SAMPLE : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        sample_hold = (state == SAMPLE);
    end

    // Current bit resolved by the comparator, then the next lower bit raised as the new trial.
    always_comb begin
        decided      = dac_code;
        decided[idx] = bus.cmp_in;
        trial_next   = decided;
        if (!last_bit) begin
            trial_next[idx_dn] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dac_code   <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            busy       <= 1'b0;
            idx        <= IDX_TOP;
        end else begin
            data_valid <= 1'b0;
            busy       <= (next_state != IDLE);
            case (state)
                IDLE: begin
                    if (bus.sample_sig) begin
                        dac_code <= MSB;
                        idx      <= IDX_TOP;
                    end
                end
                CONVERT: begin
                    if (last_bit) begin
                        data_out   <= decided;
                        data_valid <= 1'b1;
                        idx        <= IDX_TOP;
                        // Back-to-back start reloads the first trial; otherwise the result is held.
                        dac_code   <= bus.sample_sig ? MSB : decided;
                    end else begin
                        dac_code <= trial_next;
                        idx      <= idx_dn;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SAR_OVERRUN_EN
    logic early;

    assign early = bus.sample_sig &&
                   ((state == SAMPLE) || ((state == CONVERT) && !last_bit));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else if (early) begin
            overrun <= 1'b1;
        end else if (bus.overrun_clr) begin
            overrun <= 1'b0;
        end
    end
`else
    logic unused_overrun_clr;

    assign unused_overrun_clr = bus.overrun_clr;
    assign overrun            = 1'b0;
`endif

    assign bus.sample_hold = sample_hold;
    assign bus.dac_code    = dac_code;
    assign bus.data_out    = data_out;
    assign bus.data_valid  = data_valid;
    assign bus.busy        = busy;
    assign bus.overrun     = overrun;
endmodule

// File: tb/tb_sar_logic.sv
// Directed bench for sar_logic with a behavioural comparator cmp_in = (vin >= dac_code).
module tb_sar_logic;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] vin;
    int         tests = 0;
    int         fails = 0;

`ifdef SAR_OVERRUN_EN
    localparam logic OVR = 1'b1;
`else
    localparam logic OVR = 1'b0;
`endif

    sar_logic_if #(.NUM_BITS(4)) bus ();

    sar_logic #(.NUM_BITS(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.cmp_in = (vin >= bus.dac_code);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic conv(input logic [3:0] v, input logic [3:0] e0, input logic [3:0] e1,
                        input logic [3:0] e2, input logic [3:0] e3, input logic [3:0] res);
        vin            = v;
        bus.sample_sig = 1'b1;
        step();
        bus.sample_sig = 1'b0;
        chk("acc_hold", bus.sample_hold, 1);
        chk("acc_dac", bus.dac_code, e0);
        chk("acc_busy", bus.busy, 1);
        step();
        chk("c1_hold", bus.sample_hold, 0);
        chk("c1_dac", bus.dac_code, e0);
        step();
        chk("c2_dac", bus.dac_code, e1);
        step();
        chk("c3_dac", bus.dac_code, e2);
        step();
        chk("c4_dac", bus.dac_code, e3);
        chk("c4_valid", bus.data_valid, 0);
        chk("c4_busy", bus.busy, 1);
        step();
        chk("done_valid", bus.data_valid, 1);
        chk("done_data", bus.data_out, res);
        chk("done_dac", bus.dac_code, res);
        chk("done_busy", bus.busy, 0);
        chk("done_hold", bus.sample_hold, 0);
        step();
        chk("post_valid", bus.data_valid, 0);
        chk("post_data", bus.data_out, res);
    endtask

    initial begin
        rst_n           = 1'b0;
        vin             = 4'd0;
        bus.sample_sig  = 1'b0;
        bus.overrun_clr = 1'b0;
        #12;
        chk("rst_hold", bus.sample_hold, 0);
        chk("rst_dac", bus.dac_code, 0);
        chk("rst_data", bus.data_out, 0);
        chk("rst_valid", bus.data_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_ovr", bus.overrun, 0);
        step();
        rst_n = 1'b1;
        step();

        conv(4'd10, 4'd8, 4'd12, 4'd10, 4'd11, 4'd10);
        conv(4'd15, 4'd8, 4'd12, 4'd14, 4'd15, 4'd15);
        conv(4'd0,  4'd8, 4'd4,  4'd2,  4'd1,  4'd0);

        // data_out holds while idle
        step();
        step();
        chk("idle_data", bus.data_out, 0);
        chk("idle_dac", bus.dac_code, 0);
        chk("idle_busy", bus.busy, 0);

        // back-to-back conversions, one start pulse every 5 cycles
        begin
            logic [3:0] vins [3];
            logic [3:0] exps [3];
            vins = '{4'd3, 4'd7, 4'd12};
            exps = '{4'd3, 4'd7, 4'd12};
            for (int k = 0; k < 4; k++) begin
                bus.sample_sig = (k < 3);
                step();
                bus.sample_sig = 1'b0;
                if (k > 0) begin
                    chk("b2b_valid", bus.data_valid, 1);
                    chk("b2b_data", bus.data_out, exps[k-1]);
                end
                if (k < 3) begin
                    vin = vins[k];
                    chk("b2b_hold", bus.sample_hold, 1);
                    chk("b2b_dac0", bus.dac_code, 8);
                    for (int c = 0; c < 4; c++) begin
                        chk("b2b_busy", bus.busy, 1);
                        chk("b2b_ovr", bus.overrun, 0);
                        step();
                        chk("b2b_nvalid", bus.data_valid, 0);
                    end
                end else begin
                    chk("b2b_end_busy", bus.busy, 0);
                    chk("b2b_end_dac", bus.dac_code, 12);
                end
            end
        end

        // early start pulse two cycles after acceptance
        vin            = 4'd6;
        bus.sample_sig = 1'b1;
        step();
        bus.sample_sig = 1'b0;
        step();
        bus.sample_sig = 1'b1;
        step();
        bus.sample_sig = 1'b0;
        chk("ovr_dac", bus.dac_code, 4);
        chk("ovr_set", bus.overrun, OVR);
        step();
        chk("ovr_dac2", bus.dac_code, 6);
        step();
        chk("ovr_dac3", bus.dac_code, 7);
        step();
        chk("ovr_valid", bus.data_valid, 1);
        chk("ovr_data", bus.data_out, 6);
        chk("ovr_busy", bus.busy, 0);
        step();
        chk("ovr_sticky", bus.overrun, OVR);
        chk("ovr_idle_busy", bus.busy, 0);
        bus.overrun_clr = 1'b1;
        step();
        bus.overrun_clr = 1'b0;
        chk("ovr_clr", bus.overrun, 0);

        // asynchronous reset during the third CONVERT cycle
        vin            = 4'd10;
        bus.sample_sig = 1'b1;
        step();
        bus.sample_sig = 1'b0;
        step();
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_dac", bus.dac_code, 0);
        chk("arst_data", bus.data_out, 0);
        chk("arst_valid", bus.data_valid, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_hold", bus.sample_hold, 0);
        chk("arst_ovr", bus.overrun, 0);
        step();
        step();
        chk("arst_hold_valid", bus.data_valid, 0);
        rst_n = 1'b1;
        step();
        chk("arst_rel_valid", bus.data_valid, 0);
        chk("arst_rel_busy", bus.busy, 0);
        conv(4'd10, 4'd8, 4'd12, 4'd10, 4'd11, 4'd10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
